// File: rtl/cpu_dbg_pkg.sv
// cpu_dbg_pkg
//   Shared types for the CPU debug/step controller and anything that decodes
//   its outputs (hex display mux, board top).
//   ctrl_state_t : encoding of cpu_step_ctrl.state
//                  HALT=0, RUN=1, STEP=2, BREAK=3
//   TICK_W       : width of the instruction tick counter
package cpu_dbg_pkg;

  localparam int TICK_W = 32;

  typedef enum logic [1:0] {
    HALT  = 2'd0,
    RUN   = 2'd1,
    STEP  = 2'd2,
    BREAK = 2'd3
  } ctrl_state_t;

endpackage

// File: rtl/btn_debounce.sv
// btn_debounce
//   Turns a raw, asynchronous, bouncing push-button into a clean one-cycle
//   press pulse. Reusable for any board button.
//   clk      in  board clock
//   reset_n  in  asynchronous active-low reset
//   btn_raw  in  raw button level, active-high, asynchronous to clk
//   press    out one-cycle pulse on a rising edge of the debounced level
//
//   The debounced level flips only after DEB_CYCLES consecutive synchronised
//   samples that disagree with it; any agreeing sample restarts the count.
//   Latency from a clean rise to press is 2 + DEB_CYCLES cycles.
module btn_debounce #(
  parameter int DEB_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic btn_raw,
  output logic press
);

  localparam int DW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [DW-1:0] LAST = DW'(DEB_CYCLES - 1);

  logic [1:0]    sync_q;
  logic [DW-1:0] stab_cnt;
  logic          deb_q;
  logic          deb_d1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q   <= '0;
      stab_cnt <= '0;
      deb_q    <= 1'b0;
      deb_d1   <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], btn_raw};
      deb_d1 <= deb_q;
      if (sync_q[1] == deb_q) begin
        stab_cnt <= '0;
      end else if (stab_cnt == LAST) begin
        // DEB_CYCLES disagreeing samples in a row: accept the new level
        deb_q    <= sync_q[1];
        stab_cnt <= '0;
      end else begin
        stab_cnt <= stab_cnt + DW'(1);
      end
    end
  end

  assign press = deb_q & ~deb_d1;

endmodule

// File: rtl/cpu_step_ctrl.sv
// cpu_step_ctrl
//   Clock-enable controller for the CPU core. Everything runs on the board
//   clock; the CPU advances only in cycles where cpu_en is high.
//   clk         in  board clock
//   reset_n     in  asynchronous active-low reset
//   mode_run    in  1 = free run, 0 = halt
//   divide      in  rate: one cpu_en per divide+1 cycles in RUN
//   step_btn    in  raw single-step button (debounced internally)
//   bp_en       in  breakpoint enable
//   bp_addr     in  breakpoint PC
//   pc          in  current CPU PC, stable between cpu_en pulses
//   cpu_en      out registered one-cycle CPU advance qualifier
//   state       out ctrl_state_t encoding of the controller state
//   tick_count  out number of cpu_en pulses since reset (wraps)
module cpu_step_ctrl
  import cpu_dbg_pkg::*;
#(
  parameter int CNT_W      = 28,
  parameter int ADDR_W     = 32,
  parameter int DEB_CYCLES = 1_000_000
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              mode_run,
  input  logic [CNT_W-1:0]  divide,
  input  logic              step_btn,
  input  logic              bp_en,
  input  logic [ADDR_W-1:0] bp_addr,
  input  logic [ADDR_W-1:0] pc,
  output logic              cpu_en,
  output logic [1:0]        state,
  output logic [TICK_W-1:0] tick_count
);

  ctrl_state_t      st_q;
  logic [CNT_W-1:0] div_cnt;
  logic             skip_q;   // suppress a break on the first pulse after RUN entry
  logic             press;
  logic             due;
  logic             bp_hit;

  btn_debounce #(
    .DEB_CYCLES (DEB_CYCLES)
  ) u_step_deb (
    .clk     (clk),
    .reset_n (reset_n),
    .btn_raw (step_btn),
    .press   (press)
  );

  // >= rather than == so that lowering divide mid-count fires next cycle
  assign due    = (div_cnt >= divide);
  assign bp_hit = bp_en && (pc == bp_addr) && !skip_q;
  assign state  = st_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      st_q       <= HALT;
      cpu_en     <= 1'b0;
      div_cnt    <= '0;
      skip_q     <= 1'b0;
      tick_count <= '0;
    end else begin
      cpu_en <= 1'b0;
      if (cpu_en) tick_count <= tick_count + TICK_W'(1);

      case (st_q)
        HALT: begin
          // mode_run checked first so it wins over a coincident press
          if (mode_run) begin
            st_q    <= RUN;
            div_cnt <= '0;
            skip_q  <= 1'b1;
          end else if (press) begin
            st_q <= STEP;
          end
        end

        RUN: begin
          if (!mode_run) begin
            st_q <= HALT;
          end else if (due) begin
            div_cnt <= '0;
            if (bp_hit) begin
              st_q <= BREAK;
            end else begin
              cpu_en <= 1'b1;
              skip_q <= 1'b0;
            end
          end else begin
            div_cnt <= div_cnt + CNT_W'(1);
          end
        end

        STEP: begin
          cpu_en <= 1'b1;
          st_q   <= HALT;
        end

        BREAK: begin
          // never straight back to RUN: mode_run must drop first
          if (press)          st_q <= STEP;
          else if (!mode_run) st_q <= HALT;
        end

        default: st_q <= HALT;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_step_ctrl.sv
module tb_cpu_step_ctrl;
  import cpu_dbg_pkg::*;

  localparam int CNT_W = 28;
  localparam int ADDR_W = 32;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              mode_run;
  logic [CNT_W-1:0]  divide;
  logic              step_btn;
  logic              bp_en;
  logic [ADDR_W-1:0] bp_addr;
  logic [ADDR_W-1:0] pc = '0;
  logic              pc_clr;
  logic              cpu_en;
  logic [1:0]        state;
  logic [31:0]       tick_count;

  cpu_step_ctrl #(.CNT_W(CNT_W), .ADDR_W(ADDR_W), .DEB_CYCLES(4)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .mode_run   (mode_run),
    .divide     (divide),
    .step_btn   (step_btn),
    .bp_en      (bp_en),
    .bp_addr    (bp_addr),
    .pc         (pc),
    .cpu_en     (cpu_en),
    .state      (state),
    .tick_count (tick_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  // simple CPU model: PC advances by 4 per enabled cycle
  always @(posedge clk) begin
    if (pc_clr)      pc <= '0;
    else if (cpu_en) pc <= pc + 32'd4;
  end

  typedef struct {
    int          c;
    logic [1:0]  st;
    logic [31:0] tk;
  } exp_t;

  exp_t        q[$];
  logic [31:0] model_tick = '0;
  int          n_tests = 0;
  int          n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=0x%0h expected=0x%0h (cyc %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic push(input int c, input logic [1:0] st);
    q.push_back('{c, st, model_tick});
    model_tick = model_tick + 32'd1;
  endtask

  task automatic at(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic drain();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (q.size() > 0 && n < 200);
    chk("queue_drain", q.size(), 0);
  endtask

  // monitor: every cpu_en pulse must match the head of the expectation queue
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].c < cyc) begin
      n_tests++;
      n_fail++;
      $display("FAIL pulse_missed actual=none expected_cyc=%0d (cyc %0d)", q[0].c, cyc);
      void'(q.pop_front());
    end
    if (cpu_en) begin
      if (q.size() == 0 || q[0].c != cyc) begin
        n_tests++;
        n_fail++;
        $display("FAIL pulse_unexpected actual_cyc=%0d expected_cyc=%0d",
                 cyc, (q.size() > 0) ? q[0].c : -1);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("pulse_cyc", cyc, e.c);
        chk("pulse_state", {30'd0, state}, {30'd0, e.st});
        chk("pulse_tick", tick_count, e.tk);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    reset_n = 1'b0; mode_run = 1'b0; divide = 3; step_btn = 1'b0;
    bp_en = 1'b0; bp_addr = '0; pc_clr = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_cpu_en", cpu_en, 0);
    chk("rst_state", state, HALT);
    chk("rst_tick", tick_count, 0);
    reset_n = 1'b1; pc_clr = 1'b0;
    @(negedge clk);

    // 1: async reset mid-RUN, during a pulse
    k = cyc; mode_run = 1'b1;
    push(k + 5, RUN); push(k + 9, RUN);
    at(k + 9);
    #1 reset_n = 1'b0;
    #1;
    chk("arst_cpu_en", cpu_en, 0);
    chk("arst_state", state, HALT);
    chk("arst_tick", tick_count, 0);
    model_tick = '0; mode_run = 1'b0;
    @(negedge clk); reset_n = 1'b1;
    repeat (20) @(negedge clk);
    chk("halt_quiet_tick", tick_count, 0);

    // 2: free run divide=3, 10 pulses
    k = cyc; mode_run = 1'b1;
    for (int i = 1; i <= 10; i++) push(k + 1 + 4 * i, RUN);
    at(k + 41); mode_run = 1'b0;
    at(k + 42);
    chk("run_tick10", tick_count, 32'd10);
    chk("run_halt", state, HALT);
    // divide=0: every cycle
    divide = 0; k = cyc; mode_run = 1'b1;
    for (int i = 0; i < 6; i++) push(k + 2 + i, RUN);
    at(k + 7); mode_run = 1'b0;
    at(k + 8);
    chk("div0_halt", state, HALT);
    drain();

    // 3: bouncing button, one step pulse 8 cycles after final rise
    divide = 3; k = cyc; step_btn = 1'b1;
    at(k + 2); step_btn = 1'b0;
    at(k + 4); step_btn = 1'b1;
    push(k + 12, HALT);
    at(k + 13);
    chk("step_back_halt", state, HALT);
    step_btn = 1'b0;
    repeat (12) @(negedge clk);
    drain();

    // 4: breakpoint at 0x10
    pc_clr = 1'b1; @(negedge clk); pc_clr = 1'b0;
    bp_en = 1'b1; bp_addr = 32'h10;
    k = cyc; mode_run = 1'b1;
    for (int i = 1; i <= 4; i++) push(k + 1 + 4 * i, RUN);
    at(k + 22);
    chk("bp_state", state, BREAK);
    chk("bp_pc", pc, 32'h10);
    k = cyc; step_btn = 1'b1;
    push(k + 8, HALT);
    at(k + 8); mode_run = 1'b0; step_btn = 1'b0;
    at(k + 9);
    chk("bp_step_halt", state, HALT);
    chk("bp_step_pc", pc, 32'h14);
    bp_en = 1'b0;
    repeat (10) @(negedge clk);
    drain();

    // 5a: mode_run rise coincident with press -> RUN, no step pulse
    k = cyc; step_btn = 1'b1;
    at(k + 6); mode_run = 1'b1;
    push(k + 11, RUN);
    at(k + 7);
    chk("simul_run", state, RUN);
    at(k + 11); mode_run = 1'b0; step_btn = 1'b0;
    at(k + 12);
    chk("simul_halt", state, HALT);
    repeat (10) @(negedge clk);
    drain();

    // 5b: RUN entry at pc==bp_addr still pulses first
    bp_en = 1'b1; bp_addr = pc;
    k = cyc; mode_run = 1'b1;
    push(k + 5, RUN);
    at(k + 5); mode_run = 1'b0;
    at(k + 6);
    chk("skip_halt", state, HALT);
    bp_en = 1'b0;
    drain();

    // 6a: tick_count wrap
    force dut.tick_count = 32'hFFFF_FFFF;
    @(negedge clk);
    release dut.tick_count;
    model_tick = 32'hFFFF_FFFF;
    divide = 0; k = cyc; mode_run = 1'b1;
    push(k + 2, RUN);
    at(k + 2); mode_run = 1'b0;
    at(k + 3);
    chk("tick_wrap", tick_count, 0);
    drain();

    // 6b: divide lowered 100 -> 2 at count 50 -> pulse next cycle
    divide = 100; k = cyc; mode_run = 1'b1;
    at(k + 51); divide = 2;
    push(k + 52, RUN);
    at(k + 52); mode_run = 1'b0;
    at(k + 53);
    chk("div_lower_halt", state, HALT);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
